// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid register stage with registered in_ready_o and optional stall counter (PIPE_SKID_STATS_EN)
module pipe_skid_reg #(
    parameter int PAYLOAD_W = 160,
    parameter int DEST_W    = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [PAYLOAD_W-1:0] in_data_i,
    input  logic [DEST_W-1:0]    in_dest_i,
    input  logic                 in_wen_i,
    input  logic                 flush_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [PAYLOAD_W-1:0] out_data_o,
    output logic [DEST_W-1:0]    out_dest_o,
    output logic                 out_wen_o,
    output logic [1:0]           occ_o
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [CNT_W-1:0]     stall_cnt_o
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t                 state;
    state_t                 stateNext;
    logic                   inReadyQ;
    logic [PAYLOAD_W-1:0]   mainData;
    logic [PAYLOAD_W-1:0]   skidData;
    logic [DEST_W-1:0]      mainDest;
    logic [DEST_W-1:0]      skidDest;
    logic                   mainWen;
    logic                   skidWen;
    logic                   inFire;
    logic                   outFire;
    logic                   loadMain;
    logic                   loadSkid;
    logic                   skidToMain;

    // A zero-width stall counter makes no sense; reject it at elaboration.
    if (CNT_W < 1) begin : gCntWidthCheck
        $error("pipe_skid_reg: CNT_W must be at least 1");
    end

    assign inFire      = in_valid_i & inReadyQ;
    assign outFire     = out_valid_o & out_ready_i;
    assign in_ready_o  = inReadyQ;
    assign out_valid_o = (state != EMPTY);
    assign occ_o       = state;
    assign out_data_o  = mainData;
    assign out_dest_o  = mainDest;
    assign out_wen_o   = mainWen & out_valid_o;

    // Next-state and entry-load decode; flush squashes every transition and load.
    always_comb begin
        stateNext  = state;
        loadMain   = 1'b0;
        loadSkid   = 1'b0;
        skidToMain = 1'b0;
        case (state)
            EMPTY: begin
                if (inFire) begin
                    loadMain  = 1'b1;
                    stateNext = ONE;
                end
            end
            ONE: begin
                if (inFire && outFire) begin
                    loadMain  = 1'b1;
                end else if (inFire) begin
                    loadSkid  = 1'b1;
                    stateNext = TWO;
                end else if (outFire) begin
                    stateNext = EMPTY;
                end
            end
            TWO: begin
                if (outFire) begin
                    skidToMain = 1'b1;
                    stateNext  = ONE;
                end
            end
            default: stateNext = EMPTY;
        endcase
        if (flush_i) begin
            stateNext  = EMPTY;
            loadMain   = 1'b0;
            loadSkid   = 1'b0;
            skidToMain = 1'b0;
        end
    end

    // State register; in_ready_o is precomputed so it never sees out_ready_i combinationally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= EMPTY;
            inReadyQ <= 1'b1;
        end else begin
            state    <= stateNext;
            inReadyQ <= (stateNext != TWO);
        end
    end

    // Entry storage; contents persist when an entry empties, only occupancy gates use.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mainData <= '0;
            mainDest <= '0;
            mainWen  <= 1'b0;
            skidData <= '0;
            skidDest <= '0;
            skidWen  <= 1'b0;
        end else begin
            if (loadMain) begin
                mainData <= in_data_i;
                mainDest <= in_dest_i;
                mainWen  <= in_wen_i;
            end else if (skidToMain) begin
                mainData <= skidData;
                mainDest <= skidDest;
                mainWen  <= skidWen;
            end
            if (loadSkid) begin
                skidData <= in_data_i;
                skidDest <= in_dest_i;
                skidWen  <= in_wen_i;
            end
        end
    end

`ifdef PIPE_SKID_STATS_EN
    logic [CNT_W-1:0] stallCnt;

    assign stall_cnt_o = stallCnt;

    // Count cycles where a bundle is held but downstream refuses it, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stallCnt <= '0;
        end else if (out_valid_o && !out_ready_i && (stallCnt != {CNT_W{1'b1}})) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 SHALL have parameter PAYLOAD_W, default 160, bit width of the carried stage bundle (results, flags, destinations).
REQ-002 SHALL have parameter DEST_W, default 4, width of the destination-register tag carried alongside the payload.
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 Ports, in order:
- clk_i, input, 1: single clock, rising edge.
- rst_ni, input, 1: asynchronous active-low reset.
- in_valid_i, input, 1: upstream bundle valid.
- in_ready_o, output, 1: stage can accept.
- in_data_i, input, PAYLOAD_W: upstream payload.
- in_dest_i, input, DEST_W: upstream destination tag.
- in_wen_i, input, 1: upstream bundle writes a register.
- flush_i, input, 1: synchronous squash of all held bundles.
- out_valid_o, output, 1: downstream bundle valid.
- out_ready_i, input, 1: downstream accepts.
- out_data_o, output, PAYLOAD_W: held payload.
- out_dest_o, output, DEST_W: held destination tag.
- out_wen_o, output, 1: held write-enable, forced 0 when out_valid_o=0.
- occ_o, output, 2: entries held (0..2).
- stall_cnt_o, output, CNT_W: stall cycles (present only with the macro).
REQ-005 One clock; reset is asynchronous and active-low (clk_i, rst_ni); the polarity and synchronicity are fixed.

Function
REQ-006 SHALL hold two entries, MAIN (drives outputs) and SKID; state EMPTY, ONE, or TWO equals occ_o = 0, 1, or 2.
REQ-007 in_ready_o SHALL come straight from a flop: 1 in EMPTY and ONE, 0 in TWO; it SHALL NOT depend combinationally on out_ready_i.
REQ-008 out_valid_o SHALL be 1 in ONE and TWO; outputs SHALL reflect MAIN only.
REQ-009 in_fire = in_valid_i & in_ready_o; out_fire = out_valid_o & out_ready_i.
REQ-010 EMPTY: in_fire loads MAIN and moves to ONE; otherwise the state holds.
REQ-011 ONE:
- in_fire & out_fire: load MAIN, stay in ONE.
- in_fire & !out_fire: load SKID, go to TWO.
- !in_fire & out_fire: go to EMPTY.
- neither: hold.
REQ-012 TWO: out_fire moves SKID into MAIN and goes to ONE; otherwise hold.
REQ-013 Latency SHALL be one cycle from in_fire to out_valid_o when empty; sustained throughput SHALL be one bundle per cycle with out_ready_i=1.
REQ-014 Order SHALL be FIFO; no bundle is duplicated or lost without flush.
REQ-015 flush_i=1 SHALL force the next state to EMPTY and override every transition; a bundle offered in the same cycle is dropped; in_ready_o is 1 the next cycle.
REQ-016 out_fire in a flush cycle SHALL still count as delivered to downstream (the downstream consumer owns that decision).
REQ-017 Payload, dest and wen in empty entries SHALL hold their old values; only valid/occupancy gate use.
REQ-018 in_valid_i asserted while in_ready_o=0 SHALL have no effect.

Reset
REQ-019 rst_ni=0 SHALL immediately, without a clock edge, force these outputs to 0: occ_o, out_valid_o, out_wen_o, out_data_o, out_dest_o, stall_cnt_o; in_ready_o SHALL go to 1.
REQ-020 Reset asserted mid-transfer SHALL discard both entries; release SHALL be synchronised by the integrator.

Configuration
REQ-021 With macro PIPE_SKID_STATS_EN defined, stall_cnt_o SHALL count cycles with out_valid_o=1 & out_ready_i=0; it SHALL saturate at all-ones and be cleared only by reset.
REQ-022 Without PIPE_SKID_STATS_EN, the port and counter SHALL be absent and behaviour is otherwise identical.

Verification
REQ-023 Reset: drive rst_ni=0 asynchronously mid-cycle -> occ_o=0, out_valid_o=0 and in_ready_o=1 before the next edge.
REQ-024 Streaming: out_ready_i=1, 8 bundles 0x1..0x8 back-to-back -> outputs 0x1..0x8 on consecutive cycles, one cycle later, occ_o=1 throughout.
REQ-025 Backpressure: out_ready_i=0, offer A, B, C -> A and B accepted, occ_o=2, in_ready_o=0, C held; raise out_ready_i -> A, B, C delivered in order.
REQ-026 Flush: occ_o=2 with flush_i=1 and in_valid_i=1 (D) -> next cycle occ_o=0, out_valid_o=0, and D never appears.
REQ-027 Wen gating: accept in_wen_i=1 dest 0x5, then empty -> out_wen_o=0 once out_valid_o=0, while out_dest_o may still read 0x5.
REQ-028 Stats (macro on, CNT_W=4): out_valid_o=1 and out_ready_i=0 for 20 cycles -> stall_cnt_o=0xF, saturated.
